// File: rtl/cond_pkg.sv
// Condition codes, NZCV flag layout and the shared condition evaluator.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_eval(input cond_e cond, input flags_t f);
    logic ok;
    case (cond)
      EQ:      ok = f.z;
      NE:      ok = !f.z;
      CS:      ok = f.c;
      CC:      ok = !f.c;
      MI:      ok = f.n;
      PL:      ok = !f.n;
      VS:      ok = f.v;
      VC:      ok = !f.v;
      HI:      ok = f.c & !f.z;
      LS:      ok = !f.c | f.z;
      GE:      ok = (f.n == f.v);
      LT:      ok = (f.n != f.v);
      GT:      ok = !f.z & (f.n == f.v);
      LE:      ok = f.z | (f.n != f.v);
      AL:      ok = 1'b1;
      NV:      ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Purpose: evaluates one 4-bit condition code against an NZCV flag set.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; no state.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       ok
);

  assign ok = cond_eval(cond_e'(cond), flags);

endmodule

// File: rtl/cond_exec_unit.sv
// Purpose: commit predicate for the execute stage over banked NZCV flags plus a then/else predication window.
// Latency: commit enables are combinational (0 cycles); flag and window state update on the next edge.
// Backpressure: Stall freezes all state and forces every commit output low.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int NUM_FSETS = 4,
  parameter int MAX_IT    = 4,
  localparam int FSEL_W   = (NUM_FSETS > 1) ? $clog2(NUM_FSETS) : 1,
  localparam int CNT_W    = $clog2(MAX_IT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic [3:0]        Cond,
  input  logic [FSEL_W-1:0] FSel,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  input  logic              ItStart,
  input  logic [CNT_W-1:0]  ItCount,
  input  logic [3:0]        ItCond,
  input  logic [MAX_IT-1:0] ItMask,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic              ItActive,
  output logic [CNT_W-1:0]  ItLeft,
  output logic              ItError
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam int                IDX_W     = (MAX_IT > 1) ? $clog2(MAX_IT) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_IT);
  localparam logic [FSEL_W:0]   NUM_BANKS = (FSEL_W + 1)'(NUM_FSETS);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   it_left, it_left_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [3:0]         it_cond_r;
  logic [MAX_IT-1:0]  it_mask_r;
  logic               it_error;
  flags_t             banks [NUM_FSETS];

  logic               fsel_ok;
  flags_t             cur_flags;
  logic               cond_ok, it_ok, member_ok, cond_raw;
  logic               it_illegal, start_ok;

  // Unimplemented bank selects read as all-zero flags.
  assign fsel_ok   = ({1'b0, FSel} < NUM_BANKS);
  assign cur_flags = fsel_ok ? banks[FSel] : '0;

  cond_check u_cond (.cond(Cond),      .flags(cur_flags), .ok(cond_ok));
  cond_check u_it   (.cond(it_cond_r), .flags(cur_flags), .ok(it_ok));

  assign it_illegal = (state == ACTIVE) || (ItCount == '0) || (ItCount > MAX_CNT);
  assign start_ok   = ItStart && !it_illegal && !Stall;
  assign member_ok  = it_mask_r[idx] ? it_ok : !it_ok;
  assign cond_raw   = (state == ACTIVE) ? (cond_ok & member_ok) : cond_ok;

  // Markers, legal or not, never commit anything themselves.
  assign CondEx   = cond_raw & !ItStart & !Stall & !reset;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & !NoWrite;
  assign MemWrite = MemW & CondEx;

  assign ItActive = (state == ACTIVE);
  assign ItLeft   = it_left;
  assign ItError  = it_error;

  always_comb begin
    state_nxt   = state;
    it_left_nxt = it_left;
    idx_nxt     = idx;
    if (!Stall) begin
      case (state)
        IDLE: begin
          if (ItStart && !it_illegal) begin
            state_nxt   = ACTIVE;
            it_left_nxt = ItCount;
            idx_nxt     = '0;
          end
        end
        ACTIVE: begin
          it_left_nxt = it_left - 1'b1;
          idx_nxt     = idx + 1'b1;
          // Last member or a taken branch ends the window.
          if (it_left == CNT_W'(1) || PCSrc) begin
            state_nxt   = IDLE;
            it_left_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      it_left   <= '0;
      idx       <= '0;
      it_cond_r <= '0;
      it_mask_r <= '0;
      it_error  <= 1'b0;
      for (int i = 0; i < NUM_FSETS; i++) banks[i] <= '0;
    end else begin
      state    <= state_nxt;
      it_left  <= it_left_nxt;
      idx      <= idx_nxt;
      it_error <= ItStart & !Stall & it_illegal;
      if (start_ok) begin
        it_cond_r <= ItCond;
        it_mask_r <= ItMask;
      end
      for (int i = 0; i < NUM_FSETS; i++) begin
        if (CondEx && FSel == FSEL_W'(i)) begin
          if (FlagW[1]) begin
            banks[i].n <= ALUFlags[3];
            banks[i].z <= ALUFlags[2];
          end
          if (FlagW[0]) begin
            banks[i].c <= ALUFlags[1];
            banks[i].v <= ALUFlags[0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench for cond_exec_unit with hand-computed expectations.
module tb_cond_exec_unit;

  localparam logic [3:0] C_EQ = 4'd0,  C_NE = 4'd1,  C_CS = 4'd2,  C_LS = 4'd9;
  localparam logic [3:0] C_VS = 4'd6,  C_LT = 4'd11, C_GT = 4'd12, C_AL = 4'd14;
  localparam logic [3:0] C_NV = 4'd15, C_HI = 4'd8;

  logic       clk;
  logic       reset;
  logic       Stall;
  logic [3:0] Cond;
  logic [1:0] FSel;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       ItStart;
  logic [2:0] ItCount;
  logic [3:0] ItCond;
  logic [3:0] ItMask;
  logic       PCSrc, RegWrite, MemWrite, CondEx, ItActive, ItError;
  logic [2:0] ItLeft;

  int errors = 0;
  int checks = 0;

  cond_exec_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Cond(Cond), .FSel(FSel),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .ItStart(ItStart), .ItCount(ItCount), .ItCond(ItCond),
    .ItMask(ItMask), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .CondEx(CondEx), .ItActive(ItActive), .ItLeft(ItLeft), .ItError(ItError)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Stall = 0; Cond = C_AL; FSel = 0; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    ItStart = 0; ItCount = 0; ItCond = 0; ItMask = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    PCS = 1; RegW = 1; MemW = 1;
    #2;
    chk("rst_condex", CondEx, 0);
    chk("rst_pcsrc", PCSrc, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_memwrite", MemWrite, 0);
    tick(); tick();
    chk("rst_itactive", ItActive, 0);
    chk("rst_itleft", ItLeft, 0);
    chk("rst_iterror", ItError, 0);
    reset = 1'b0;

    // Reset flags: bank0 = 0000
    idle_in(); Cond = C_EQ; PCS = 1; #1;
    chk("rst_bank0_eq", PCSrc, 0);
    Cond = C_NE; #1;
    chk("rst_bank0_ne", PCSrc, 1);
    Cond = C_NV; #1;
    chk("nv_false", PCSrc, 0);
    Cond = C_AL; PCS = 0; MemW = 1; #1;
    chk("al_memwrite", MemWrite, 1);
    tick();

    // 1: CMP into bank0 (N=0 Z=0 C=1 V=0), then BGT / BLT
    idle_in(); FlagW = 2'b11; ALUFlags = 4'b0010; RegW = 1; NoWrite = 1; #1;
    chk("cmp_condex", CondEx, 1);
    chk("cmp_nowrite", RegWrite, 0);
    tick();
    idle_in(); Cond = C_GT; PCS = 1; #1;
    chk("bgt_taken", PCSrc, 1);
    tick();
    idle_in(); Cond = C_LT; PCS = 1; #1;
    chk("blt_not_taken", PCSrc, 0);
    tick();

    // 2: bank isolation, bank1 gets Z=1
    idle_in(); FSel = 1; FlagW = 2'b11; ALUFlags = 4'b0100; #1;
    tick();
    idle_in(); Cond = C_EQ; PCS = 1; FSel = 0; #1;
    chk("beq_bank0", PCSrc, 0);
    FSel = 1; #1;
    chk("beq_bank1", PCSrc, 1);
    FSel = 0; Cond = C_CS; #1;
    chk("bank0_c_kept", PCSrc, 1);
    tick();
    // C,V-only write into bank1 -> bank1 = 0111
    idle_in(); FSel = 1; FlagW = 2'b01; ALUFlags = 4'b1011; #1;
    tick();
    idle_in(); FSel = 1; PCS = 1; Cond = C_VS; #1;
    chk("cv_write_vs", PCSrc, 1);
    Cond = C_HI; #1;
    chk("cv_write_hi", PCSrc, 0);
    Cond = C_LS; #1;
    chk("cv_write_ls", PCSrc, 1);
    Cond = C_EQ; #1;
    chk("nz_kept_eq", PCSrc, 1);
    tick();

    // 3: window EQ, mask 101, three AL ADDs on bank1 (Z=1)
    idle_in(); FSel = 1; RegW = 1; ItStart = 1; ItCount = 3; ItCond = C_EQ; ItMask = 4'b0101; #1;
    chk("marker_condex", CondEx, 0);
    chk("marker_regwrite", RegWrite, 0);
    tick();
    chk("win_open", ItActive, 1);
    chk("win_left3", ItLeft, 3);
    idle_in(); FSel = 1; RegW = 1; #1;
    chk("win_m0", RegWrite, 1);
    tick();
    chk("win_left2", ItLeft, 2);
    #1;
    chk("win_m1", RegWrite, 0);
    tick();
    chk("win_left1", ItLeft, 1);
    chk("win_still_open", ItActive, 1);
    #1;
    chk("win_m2", RegWrite, 1);
    tick();
    chk("win_closed", ItActive, 0);
    chk("win_left0", ItLeft, 0);

    // 4: illegal markers
    idle_in(); ItStart = 1; ItCount = 0; RegW = 1; #1;
    chk("ill0_regwrite", RegWrite, 0);
    tick();
    chk("ill0_err", ItError, 1);
    chk("ill0_inactive", ItActive, 0);
    idle_in(); #1;
    tick();
    chk("ill0_err_pulse", ItError, 0);
    idle_in(); ItStart = 1; ItCount = 5; #1;
    tick();
    chk("ill5_err", ItError, 1);
    chk("ill5_inactive", ItActive, 0);
    idle_in(); FSel = 1; ItStart = 1; ItCount = 3; ItCond = C_AL; ItMask = 4'b1111; #1;
    tick();
    chk("win2_left3", ItLeft, 3);
    idle_in(); FSel = 1; RegW = 1; ItStart = 1; ItCount = 2; #1;
    chk("nested_regwrite", RegWrite, 0);
    tick();
    chk("nested_err", ItError, 1);
    chk("nested_left2", ItLeft, 2);
    chk("nested_active", ItActive, 1);

    // 5: stall two cycles with ItLeft=2, attempted flag clear on bank1
    idle_in(); FSel = 1; Stall = 1; RegW = 1; PCS = 1; FlagW = 2'b11; ALUFlags = 4'b0000; #1;
    chk("stall_regwrite", RegWrite, 0);
    chk("stall_pcsrc", PCSrc, 0);
    chk("stall_condex", CondEx, 0);
    tick();
    chk("stall_left_a", ItLeft, 2);
    chk("stall_err_clear", ItError, 0);
    tick();
    chk("stall_left_b", ItLeft, 2);
    idle_in(); FSel = 1; Cond = C_EQ; PCS = 1; #1;
    chk("stall_flags_kept", PCSrc, 1);
    tick();
    chk("branch_closes", ItActive, 0);
    chk("branch_left0", ItLeft, 0);

    // 6: reset mid-window with bank2 = 1111
    idle_in(); FSel = 2; FlagW = 2'b11; ALUFlags = 4'b1111; #1;
    tick();
    idle_in(); FSel = 2; Cond = C_EQ; PCS = 1; #1;
    chk("bank2_set", PCSrc, 1);
    idle_in(); ItStart = 1; ItCount = 3; ItCond = C_AL; ItMask = 4'b1111; #1;
    tick();
    idle_in(); RegW = 1; #1;
    tick();
    chk("pre_rst_left2", ItLeft, 2);
    reset = 1'b1; RegW = 1; PCS = 1; MemW = 1; #1;
    chk("midrst_condex", CondEx, 0);
    chk("midrst_regwrite", RegWrite, 0);
    tick();
    reset = 1'b0;
    chk("midrst_inactive", ItActive, 0);
    chk("midrst_left0", ItLeft, 0);
    idle_in(); FSel = 2; Cond = C_EQ; PCS = 1; #1;
    chk("midrst_bank2", PCSrc, 0);
    FSel = 1; Cond = C_NE; #1;
    chk("midrst_bank1", PCSrc, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
